// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
//   Sits between the processor data-memory port and the RAM. Addresses below
//   MMIO_BASE pass through to RAM. Addresses at or above MMIO_BASE hit a small
//   register window:
//     0 TX_DATA  W: push byte into TX FIFO. R: 0
//     1 STATUS   R: {irq_pend, ovf, full, empty}. W: bit2 clears ovf, bit3 clears irq_pend
//     2 CYCLE    R: free-running cycle counter. W: ignored
//     3 LEDS     R/W: 16-bit LED register
//     4 COMPARE  R/W timer compare (only with BRIDGE_TIMER_IRQ_EN)
//   Both regions return read data one cycle after the address, so the CPU sees
//   one uniform memory.
//
// Optional feature macro: BRIDGE_TIMER_IRQ_EN (COMPARE register + timer irq).
//
// Ports
//   clock, reset      single clock, synchronous active-high reset
//   cpu_addr/wren/wdata/rdata   processor data port (rdata 1 cycle after addr)
//   ram_addr/wren/wdata/rdata   RAM port (RAM has registered read data)
//   tx_data/tx_valid/tx_ready   TX byte stream out of the FIFO
//   leds              LED register
//   irq               timer interrupt (0 when the feature is disabled)
//
// TX stream handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data shows the head byte; a byte is transferred on every posedge where
// tx_valid & tx_ready are both high. tx_valid does not depend on tx_ready.

module dmem_mmio_bridge #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hF00,
   parameter int                    FIFO_DEPTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           cpu_addr,
   input  logic                  cpu_wren,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wren,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [15:0]           leds,
   output logic                  irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [ADDR_WIDTH-1:0] OFF_TX     = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] OFF_CYCLE  = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] OFF_LEDS   = ADDR_WIDTH'(3);
`ifdef BRIDGE_TIMER_IRQ_EN
   localparam logic [ADDR_WIDTH-1:0] OFF_CMP    = ADDR_WIDTH'(4);
`endif

   // ---------------- decode ----------------
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_mmio;
   logic                  w_wr_tx;
   logic                  w_wr_status;
   logic                  w_wr_leds;
   logic                  w_unused_addr_hi;

   assign w_addr      = cpu_addr[ADDR_WIDTH-1:0];
   assign w_mmio      = (w_addr >= MMIO_BASE);
   assign w_off       = w_addr - MMIO_BASE;
   assign w_wr_tx     = cpu_wren && w_mmio && (w_off == OFF_TX);
   assign w_wr_status = cpu_wren && w_mmio && (w_off == OFF_STATUS);
   assign w_wr_leds   = cpu_wren && w_mmio && (w_off == OFF_LEDS);

   // Address bits above the decoded width are intentionally ignored.
   assign w_unused_addr_hi = ^cpu_addr[31:ADDR_WIDTH];

   // ---------------- RAM pass-through ----------------
   assign ram_addr  = w_addr;
   assign ram_wren  = cpu_wren & ~w_mmio;
   assign ram_wdata = cpu_wdata;

   // ---------------- registers ----------------
   logic [7:0]            r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf;
   logic [31:0]           r_cycle;
   logic [15:0]           r_leds;
   logic                  r_sel_q;
   logic [DATA_WIDTH-1:0] r_mmio_q;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_irq_pend;
   logic [DATA_WIDTH-1:0] w_rd_val;

   assign w_empty = (r_count == CW'(0));
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = ~w_empty & tx_ready;
   // A push into a full FIFO still lands when the same edge pops a byte.
   assign w_push  = w_wr_tx & (~w_full | w_pop);
   assign w_drop  = w_wr_tx & w_full & ~w_pop;

   assign tx_valid = ~w_empty;
   assign tx_data  = r_mem[r_rd_ptr];
   assign leds     = r_leds;

   // ---------------- optional timer interrupt ----------------
`ifdef BRIDGE_TIMER_IRQ_EN
   logic [31:0] r_compare;
   logic        r_irq_pend;
   logic        w_wr_cmp;

   assign w_wr_cmp   = cpu_wren && w_mmio && (w_off == OFF_CMP);
   assign w_irq_pend = r_irq_pend;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_compare  <= 32'hFFFF_FFFF;
         r_irq_pend <= 1'b0;
      end else begin
         if (w_wr_cmp) begin
            r_compare <= cpu_wdata[31:0];
         end
         // A match on the same edge as a clear keeps the flag set.
         if (r_cycle == r_compare) begin
            r_irq_pend <= 1'b1;
         end else if (w_wr_status && cpu_wdata[3]) begin
            r_irq_pend <= 1'b0;
         end
      end
   end
`else
   assign w_irq_pend = 1'b0;
`endif

   assign irq = w_irq_pend;

   // ---------------- MMIO read mux ----------------
   always_comb begin
      w_rd_val = '0;
      if (w_mmio) begin
         case (w_off)
            OFF_STATUS: w_rd_val = DATA_WIDTH'({w_irq_pend, r_ovf, w_full, w_empty});
            OFF_CYCLE:  w_rd_val = DATA_WIDTH'(r_cycle);
            OFF_LEDS:   w_rd_val = DATA_WIDTH'(r_leds);
`ifdef BRIDGE_TIMER_IRQ_EN
            OFF_CMP:    w_rd_val = DATA_WIDTH'(r_compare);
`endif
            default:    w_rd_val = '0;
         endcase
      end
   end

   // Registered MMIO read data lines up with the RAM's registered read data.
   assign cpu_rdata = r_sel_q ? r_mmio_q : ram_rdata;

   // ---------------- FIFO storage (no reset needed) ----------------
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= cpu_wdata[7:0];
      end
   end

   // ---------------- control state ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_cycle  <= '0;
         r_leds   <= '0;
         r_sel_q  <= 1'b0;
         r_mmio_q <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         // Overflow is sticky; a drop on the same edge as a clear wins.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_wr_status && cpu_wdata[2]) begin
            r_ovf <= 1'b0;
         end

         r_cycle <= r_cycle + 32'd1;

         if (w_wr_leds) begin
            r_leds <= cpu_wdata[15:0];
         end

         r_sel_q  <= w_mmio;
         r_mmio_q <= w_rd_val;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM model, linear stimulus sequence,
// immediate-assertion checks and a one-line summary.

module tb_dmem_mmio_bridge;

`ifdef BRIDGE_TIMER_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clock;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_wren;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic [11:0] ram_addr;
   logic        ram_wren;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] leds;
   logic        irq;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   dmem_mmio_bridge dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_wren  (cpu_wren),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_wren  (ram_wren),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .leds      (leds),
      .irq       (irq)
   );

   // RAM with registered read data
   logic [31:0] ram_mem [0:4095];
   always @(posedge clock) begin
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
      cpu_addr  = a;
      cpu_wren  = we;
      cpu_wdata = d;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(a, 1'b1, d);
      step();
   endtask

   task automatic rd(input logic [31:0] a);
      drive(a, 1'b0, 32'd0);
      step();
   endtask

   task automatic idle();
      drive(32'd0, 1'b0, 32'd0);
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset    = 1'b1;
      tx_ready = 1'b0;
      drive(32'd0, 1'b0, 32'd0);
      step();
      step();
      chk("rst_leds",     32'(leds),     32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_irq",      32'(irq),      32'h0);

      // Counter starts at 0 on the first edge after reset release.
      reset = 1'b0;
      idle();                                  // samples cycle 0
      idle();                                  // samples cycle 1
      rd(32'hF02);  chk("cycle_first",  cpu_rdata, 32'd2);
      rd(32'hF02);  chk("cycle_second", cpu_rdata, 32'd3);
      rd(32'hF01);  chk("status_idle",  cpu_rdata, 32'h1);

      // RAM pass-through
      drive(32'h010, 1'b1, 32'h5);
      #1;
      chk("ram_wren_low",  32'(ram_wren), 32'h1);
      chk("ram_addr_low",  32'(ram_addr), 32'h010);
      step();
      rd(32'h010);  chk("ram_readback", cpu_rdata, 32'h5);

      // LED register; MMIO never writes RAM
      drive(32'hF03, 1'b1, 32'hAB);
      #1;
      chk("ram_wren_mmio", 32'(ram_wren), 32'h0);
      step();
      chk("leds_ab", 32'(leds), 32'h00AB);
      rd(32'hF03);  chk("leds_rd_ab", cpu_rdata, 32'h00AB);
      wr(32'hF03, 32'hFFFF_1234);
      chk("leds_1234", 32'(leds), 32'h1234);
      rd(32'hF03);  chk("leds_rd_upper0", cpu_rdata, 32'h0000_1234);

      // Fill past capacity with the sink stalled: 9th byte dropped, ovf set.
      for (int i = 1; i <= 9; i++) wr(32'hF00, 32'(i));
      chk("fill_valid", 32'(tx_valid), 32'h1);
      chk("fill_head",  32'(tx_data),  32'h01);
      rd(32'hF01);  chk("status_full_ovf", cpu_rdata, 32'h6);
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("drain_valid", 32'(tx_valid), 32'h1);
         chk("drain_data",  32'(tx_data),  32'(i));
         idle();
      end
      chk("drained_valid", 32'(tx_valid), 32'h0);
      rd(32'hF01);  chk("status_empty_ovf", cpu_rdata, 32'h5);

      // Clear ovf, refill exactly to full, then push+pop while full.
      wr(32'hF01, 32'h4);
      rd(32'hF01);  chk("status_ovf_clr", cpu_rdata, 32'h1);
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(32'hF00, 32'h10 + 32'(i));
      rd(32'hF01);  chk("status_full", cpu_rdata, 32'h2);
      tx_ready = 1'b1;
      wr(32'hF00, 32'h77);                     // pops 0x10, pushes 0x77
      tx_ready = 1'b0;
      rd(32'hF01);  chk("status_pushpop_full", cpu_rdata, 32'h2);
      chk("pushpop_head", 32'(tx_data), 32'h11);
      tx_ready = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         chk("drain2_data", 32'(tx_data), 32'h10 + 32'(i));
         idle();
      end
      chk("last_valid", 32'(tx_valid), 32'h1);
      chk("last_data",  32'(tx_data),  32'h77);
      idle();
      chk("drain2_empty", 32'(tx_valid), 32'h0);

      // Push while empty with tx_ready high: only the push happens.
      wr(32'hF00, 32'h42);
      chk("empty_pushpop_valid", 32'(tx_valid), 32'h1);
      chk("empty_pushpop_data",  32'(tx_data),  32'h42);
      idle();
      chk("empty_pushpop_drain", 32'(tx_valid), 32'h0);

      // Overflow again, then clear it while full.
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(32'hF00, 32'h20 + 32'(i));
      rd(32'hF01);  chk("status_ovf2", cpu_rdata, 32'h6);
      wr(32'hF01, 32'h4);
      rd(32'hF01);  chk("status_ovf2_clr", cpu_rdata, 32'h2);
      rd(32'hF05);  chk("unmapped_rd", cpu_rdata, 32'h0);
      rd(32'hF04);  chk("cmp_rd_rst", cpu_rdata, IRQ_EN ? 32'hFFFF_FFFF : 32'h0);

      // Upper address bits are ignored.
      drive(32'h0000_1010, 1'b1, 32'h1234);
      #1;
      chk("hi_addr_wren", 32'(ram_wren), 32'h1);
      chk("hi_addr_ram",  32'(ram_addr), 32'h010);
      step();
      rd(32'h010);  chk("hi_addr_readback", cpu_rdata, 32'h1234);
      drive(32'h0000_1F03, 1'b1, 32'h55);
      #1;
      chk("hi_mmio_wren", 32'(ram_wren), 32'h0);
      step();
      chk("hi_mmio_leds", 32'(leds), 32'h0055);

      // Reset in the middle of an access with a full FIFO.
      reset = 1'b1;
      rd(32'hF03);
      reset = 1'b0;
      chk("rst2_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst2_leds",     32'(leds),     32'h0);
      chk("rst2_irq",      32'(irq),      32'h0);
      rd(32'hF01);  chk("rst2_status", cpu_rdata, 32'h1);          // edge 1, cycle 0
      rd(32'hF04);  chk("rst2_cmp", cpu_rdata, IRQ_EN ? 32'hFFFF_FFFF : 32'h0);  // edge 2
      wr(32'hF04, 32'd10);                                          // edge 3

      // irq_pend rises at the edge sampling cycle==10, i.e. non-reset edge 11.
      for (int n = 4; n <= 11; n++) begin
         idle();
         chk("irq_timing", 32'(irq), (IRQ_EN && n == 11) ? 32'h1 : 32'h0);
      end
      rd(32'hF01);  chk("status_irq", cpu_rdata, IRQ_EN ? 32'h9 : 32'h1);   // edge 12
      chk("irq_held", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
      wr(32'hF01, 32'h8);                                           // edge 13
      chk("irq_clr", 32'(irq), 32'h0);
      rd(32'hF02);  chk("cycle_after_rst2", cpu_rdata, 32'd13);     // edge 14

      // Clear on the same edge as a new match: the set wins.
      wr(32'hF04, 32'd20);                                          // edge 15
      for (int n = 16; n <= 20; n++) idle();
      wr(32'hF01, 32'h8);                                           // edge 21 samples cycle 20
      chk("irq_set_wins", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
      wr(32'hF01, 32'h8);
      chk("irq_clr2", 32'(irq), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
